// File: rtl/debounce_detect.sv
// debounce_detect
//
// Multi-channel input conditioner. Each channel synchronises an asynchronous
// raw pin, then accepts a level change only after the synchronised value has
// differed from the current debounced level for DB_CYCLES consecutive
// qualifying ticks. An accepted change updates Pin_Out and produces a
// one-cycle edge pulse that lines up with the first cycle of the new level.
//
// Parameters:
//   CH          number of independent channels (>= 1)
//   SYNC_STAGES synchroniser depth per channel (>= 2)
//   DB_CYCLES   qualifying ticks needed to accept a change (>= 1)
//   RST_LEVEL   level loaded into the synchroniser and Pin_Out at reset
//
// Ports:
//   CLK      in   1   single clock, rising edge
//   RSTn     in   1   synchronous active-low reset
//   Pin_In   in   CH  raw asynchronous inputs
//   Tick     in   1   debounce count enable (tie high to count every cycle)
//   Pin_Out  out  CH  debounced level per channel
//   H2L_Sig  out  CH  one-cycle pulse on an accepted high-to-low change
//   L2H_Sig  out  CH  one-cycle pulse on an accepted low-to-high change
//   Busy     out  CH  high while a channel is qualifying a pending change
module debounce_detect #(
    parameter int   CH          = 4,
    parameter int   SYNC_STAGES = 2,
    parameter int   DB_CYCLES   = 16,
    parameter logic RST_LEVEL   = 1'b1
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic [CH-1:0] Pin_In,
    input  logic          Tick,
    output logic [CH-1:0] Pin_Out,
    output logic [CH-1:0] H2L_Sig,
    output logic [CH-1:0] L2H_Sig,
    output logic [CH-1:0] Busy
);

    localparam int             CW       = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_QUAL = 1'b1
    } state_t;

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] r_sync;
            state_t                 r_state;
            logic [CW-1:0]          r_cnt;
            logic                   r_pin_out;
            logic                   r_h2l;
            logic                   r_l2h;

            logic                   w_s;
            logic                   w_diff;
            logic                   w_accept;

            assign w_s      = r_sync[SYNC_STAGES-1];
            assign w_diff   = w_s ^ r_pin_out;
            // Accept is evaluated in either state so that DB_CYCLES = 1
            // takes the change on the very first edge S differs.
            assign w_accept = w_diff & Tick & (r_cnt == CNT_LAST);

            always_ff @(posedge CLK) begin
                if (!RSTn) begin
                    r_sync    <= {SYNC_STAGES{RST_LEVEL}};
                    r_state   <= ST_IDLE;
                    r_cnt     <= '0;
                    r_pin_out <= RST_LEVEL;
                    r_h2l     <= 1'b0;
                    r_l2h     <= 1'b0;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], Pin_In[gi]};
                    r_h2l  <= 1'b0;
                    r_l2h  <= 1'b0;
                    if (w_accept) begin
                        r_pin_out <= w_s;
                        r_cnt     <= '0;
                        r_state   <= ST_IDLE;
                        r_l2h     <= w_s;
                        r_h2l     <= ~w_s;
                    end else if (w_diff) begin
                        // Counter stops at CNT_LAST because reaching it with
                        // Tick high always takes the accept branch.
                        r_state <= ST_QUAL;
                        if (Tick) begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end else begin
                        // Level matches again: a pending change was a glitch.
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end
                end
            end

            assign Pin_Out[gi] = r_pin_out;
            assign H2L_Sig[gi] = r_h2l;
            assign L2H_Sig[gi] = r_l2h;
            assign Busy[gi]    = (r_state == ST_QUAL);
        end
    endgenerate

endmodule

// File: tb/tb_debounce_detect.sv
// Testbench for debounce_detect (CH=4, SYNC_STAGES=2, DB_CYCLES=4, RST_LEVEL=1).
// Stimulus pushes the expected edge pulses (cycle, H2L, L2H, Pin_Out) into a
// queue; a monitor pops and compares every cycle a pulse appears.
module tb_debounce_detect;

    logic       CLK = 1'b0;
    logic       RSTn;
    logic [3:0] Pin_In;
    logic       Tick;
    logic [3:0] Pin_Out;
    logic [3:0] H2L_Sig;
    logic [3:0] L2H_Sig;
    logic [3:0] Busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         cyc;
        logic [3:0] h2l;
        logic [3:0] l2h;
        logic [3:0] pout;
    } exp_t;

    exp_t q[$];

    debounce_detect #(
        .CH          (4),
        .SYNC_STAGES (2),
        .DB_CYCLES   (4),
        .RST_LEVEL   (1'b1)
    ) dut (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .Pin_In  (Pin_In),
        .Tick    (Tick),
        .Pin_Out (Pin_Out),
        .H2L_Sig (H2L_Sig),
        .L2H_Sig (L2H_Sig),
        .Busy    (Busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end else begin
            $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
        end
    endtask

    task automatic wait_neg(input int n);
        for (int k = 0; k < n; k++) @(negedge CLK);
    endtask

    task automatic push(input int c, input logic [3:0] h, input logic [3:0] l, input logic [3:0] p);
        exp_t e;
        e.cyc = c; e.h2l = h; e.l2h = l; e.pout = p;
        q.push_back(e);
    endtask

    // Monitor: every pulse observed must match the head of the queue.
    always @(negedge CLK) begin
        if ((H2L_Sig | L2H_Sig) != 4'b0000) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: h2l=%b l2h=%b pout=%b at cycle %0d, none expected",
                         H2L_Sig, L2H_Sig, Pin_Out, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pulse_cycle", cyc, e.cyc);
                chk("pulse_h2l", {28'd0, H2L_Sig}, {28'd0, e.h2l});
                chk("pulse_l2h", {28'd0, L2H_Sig}, {28'd0, e.l2h});
                chk("pulse_pout", {28'd0, Pin_Out}, {28'd0, e.pout});
                chk("pulse_exclusive", {28'd0, H2L_Sig & L2H_Sig}, 32'd0);
            end
        end
    end

    initial begin
        int   t0;
        logic seen;

        Pin_In = 4'hF;
        Tick   = 1'b1;
        RSTn   = 1'b0;
        wait_neg(3);
        chk("reset_pout", {28'd0, Pin_Out}, 32'hF);
        chk("reset_busy", {28'd0, Busy}, 32'h0);
        chk("reset_pulses", {28'd0, H2L_Sig | L2H_Sig}, 32'h0);
        RSTn = 1'b1;
        wait_neg(8);
        chk("post_reset_pout", {28'd0, Pin_Out}, 32'hF);

        // Clean fall on ch0: accepted at edge 6, Busy after edges 3..5.
        t0 = cyc;
        Pin_In[0] = 1'b0;
        push(t0 + 6, 4'b0001, 4'b0000, 4'b1110);
        for (int k = 1; k <= 7; k++) begin
            @(negedge CLK);
            chk($sformatf("ch0_busy_e%0d", k), {31'd0, Busy[0]}, {31'd0, (k >= 3 && k <= 5)});
        end
        chk("ch0_fall_pout", {28'd0, Pin_Out}, 32'hE);
        t0 = cyc;
        Pin_In[0] = 1'b1;
        push(t0 + 6, 4'b0000, 4'b0001, 4'b1111);
        wait_neg(9);

        // Glitch on ch1: low for 3 cycles, Busy pulses, no accept.
        t0 = cyc;
        seen = 1'b0;
        Pin_In[1] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge CLK);
            if (k == 3) Pin_In[1] = 1'b1;
            if (Busy[1]) seen = 1'b1;
        end
        chk("glitch_busy_seen", {31'd0, seen}, 32'd1);
        chk("glitch_pout", {28'd0, Pin_Out}, 32'hF);
        chk("glitch_busy_clear", {28'd0, Busy}, 32'h0);

        // Tick gating on ch2: Tick high 1 cycle in 4, accept on 4th qualifying tick (edge 17).
        t0 = cyc;
        Pin_In[2] = 1'b0;
        Tick = 1'b1;
        push(t0 + 17, 4'b0100, 4'b0000, 4'b1011);
        for (int k = 1; k <= 24; k++) begin
            @(negedge CLK);
            if (k == 16) chk("tick_before_accept", {31'd0, Pin_Out[2]}, 32'd1);
            if (k == 17) chk("tick_at_accept", {31'd0, Pin_Out[2]}, 32'd0);
            Tick = ((k % 4) == 0);
        end
        Tick = 1'b1;
        t0 = cyc;
        Pin_In[2] = 1'b1;
        push(t0 + 6, 4'b0000, 4'b0100, 4'b1111);
        wait_neg(9);

        // Independence: bring ch3 low, then ch0 falls and ch3 rises together.
        t0 = cyc;
        Pin_In[3] = 1'b0;
        push(t0 + 6, 4'b1000, 4'b0000, 4'b0111);
        wait_neg(9);
        t0 = cyc;
        Pin_In[0] = 1'b0;
        Pin_In[3] = 1'b1;
        push(t0 + 6, 4'b0001, 4'b1000, 4'b1110);
        seen = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            if (Busy[2:1] != 2'b00) seen = 1'b1;
        end
        chk("indep_ch12_idle", {31'd0, seen}, 32'd0);
        t0 = cyc;
        Pin_In[0] = 1'b1;
        push(t0 + 6, 4'b0000, 4'b0001, 4'b1111);
        wait_neg(9);

        // Reset on the edge that would accept ch1.
        t0 = cyc;
        Pin_In[1] = 1'b0;
        wait_neg(5);
        chk("rst_mid_busy_before", {31'd0, Busy[1]}, 32'd1);
        RSTn = 1'b0;
        @(negedge CLK);
        chk("rst_mid_pout", {28'd0, Pin_Out}, 32'hF);
        chk("rst_mid_busy", {28'd0, Busy}, 32'h0);
        Pin_In[1] = 1'b1;
        @(negedge CLK);
        RSTn = 1'b1;
        wait_neg(10);
        chk("rst_mid_after_pout", {28'd0, Pin_Out}, 32'hF);

        // Bounce on ch0: toggles every 2 cycles, last toggle (to 0) at k=20.
        t0 = cyc;
        Pin_In[0] = 1'b0;
        push(t0 + 26, 4'b0001, 4'b0000, 4'b1110);
        for (int k = 1; k <= 30; k++) begin
            @(negedge CLK);
            if (k <= 20 && (k % 2) == 0) Pin_In[0] = ~Pin_In[0];
        end
        chk("bounce_pout", {28'd0, Pin_Out}, 32'hE);
        t0 = cyc;
        Pin_In[0] = 1'b1;
        push(t0 + 6, 4'b0000, 4'b0001, 4'b1111);
        wait_neg(10);

        chk("queue_drained", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debounce_detect.md
DEBOUNCE_DETECT -- requirements
Module: debounce_detect

Interface
REQ-001 Parameter CH, default 4: number of independent input channels, CH >= 1.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser depth per channel, SYNC_STAGES >= 2.
REQ-003 Parameter DB_CYCLES, default 16: qualifying ticks required to accept a level change, DB_CYCLES >= 1.
REQ-004 Parameter RST_LEVEL, default 1'b1: level loaded into synchroniser and Pin_Out at reset.
REQ-005 The block SHALL have one clock and a synchronous, active-low reset: CLK and RSTn.
REQ-006 CLK  input  1  single clock; all state updates on its rising edge.
REQ-007 RSTn  input  1  synchronous active-low reset, sampled on the CLK rising edge.
REQ-008 Pin_In  input  CH  asynchronous raw inputs, one bit per channel.
REQ-009 Tick  input  1  debounce-count enable; tie high to count every CLK cycle.
REQ-010 Pin_Out  output  CH  debounced level per channel, registered.
REQ-011 H2L_Sig  output  CH  one-cycle pulse on an accepted high-to-low change, registered.
REQ-012 L2H_Sig  output  CH  one-cycle pulse on an accepted low-to-high change, registered.
REQ-013 Busy  output  CH  high while the channel is qualifying a pending change, registered.

Function
REQ-014 Each channel SHALL pass Pin_In[i] through a SYNC_STAGES-deep flop chain; the last stage is S[i].
REQ-015 Channels SHALL be fully independent; no shared counter or arbitration.
REQ-016 Each channel SHALL implement a two-state FSM, IDLE and QUAL, plus a counter of width clog2(DB_CYCLES+1).
REQ-017 IDLE: when S[i] == Pin_Out[i], the counter SHALL be held at 0.
REQ-018 IDLE->QUAL: on an edge where S[i] != Pin_Out[i], the FSM SHALL move to QUAL; if Tick = 1, the counter SHALL increment.
REQ-019 QUAL: on each edge where S[i] != Pin_Out[i] and Tick = 1, the counter SHALL increment; Tick = 0 SHALL hold it.
REQ-020 QUAL->IDLE (glitch): on any edge where S[i] == Pin_Out[i], the counter SHALL clear to 0 and no pulse SHALL be issued, regardless of Tick.
REQ-021 Accept: on the edge where S[i] != Pin_Out[i], Tick = 1 and the counter == DB_CYCLES-1, the block SHALL:
- load Pin_Out[i] <= S[i];
- clear the counter;
- return the FSM to IDLE;
- register a pulse on L2H_Sig[i] if S[i] = 1, or on H2L_Sig[i] if S[i] = 0.
REQ-022 Pulses SHALL be exactly one CLK cycle wide and coincide with the first cycle Pin_Out shows the new level.
REQ-023 H2L_Sig[i] and L2H_Sig[i] SHALL never be high in the same cycle.
REQ-024 Busy[i] SHALL be 1 exactly while the FSM is in QUAL.
REQ-025 Latency with Tick held high: Pin_Out changes at the (SYNC_STAGES+DB_CYCLES)th rising edge after a clean Pin_In change (18 cycles at default parameters).
REQ-026 A disturbance seen at S[i] for fewer than DB_CYCLES consecutive ticks SHALL leave Pin_Out, H2L_Sig and L2H_Sig unchanged.
REQ-027 With DB_CYCLES = 1 and Tick = 1, the block SHALL behave as a synchronised edge detector: change accepted one edge after S[i] differs.
REQ-028 The counter SHALL never exceed DB_CYCLES-1 and SHALL never wrap.

Reset
REQ-029 On an edge with RSTn = 0:
- all synchroniser stages and Pin_Out SHALL load RST_LEVEL;
- counters SHALL clear to 0 and FSMs SHALL return to IDLE;
- H2L_Sig, L2H_Sig and Busy SHALL be 0.
REQ-030 Reset SHALL take priority over an accept on the same edge; the qualification is aborted with no pulse.
REQ-031 After RSTn deasserts with Pin_In == RST_LEVEL, no pulse SHALL be generated.

Verification (CH=4, SYNC_STAGES=2, DB_CYCLES=4, RST_LEVEL=1, Tick=1 unless stated)
REQ-032 Ch0 clean fall: Pin_In[0] 1->0 held -> Pin_Out[0]=0 and H2L_Sig[0]=1 for one cycle at edge 6; Busy[0]=1 for edges 3-5.
REQ-033 Glitch: Pin_In[1] low for 3 cycles -> Busy[1] pulses; Pin_Out[1] stays 1; no pulse on H2L_Sig or L2H_Sig.
REQ-034 Tick gating: Tick high 1 cycle in 4 and Pin_In[2] 1->0 held -> accept after the 4th qualifying tick, not before.
REQ-035 Independence: ch0 falls and ch3 rises simultaneously -> H2L_Sig[0] and L2H_Sig[3] pulse in the same cycle; ch1 and ch2 stay idle.
REQ-036 Reset mid-qualification: RSTn=0 on the edge that would accept -> no pulse; Pin_Out=4'b1111; Busy=0.
REQ-037 Bounce: Pin_In[0] toggles every 2 cycles for 20 cycles, then holds 0 -> exactly one H2L_Sig[0] pulse, 6 edges after the final toggle.
